// File: rtl/register_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package register_scoreboard_pkg;

  localparam int PC_IDX = 15;
  localparam int NREGS  = 15;
  localparam int CNT_W  = 2;

  typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/register_scoreboard_if.sv
// Issue/writeback bundle between the ID stage and the register scoreboard.
interface register_scoreboard_if;
  import register_scoreboard_pkg::*;

  logic     issue_valid;
  logic     issue_wb_en;
  reg_idx_t issue_dest;
  reg_idx_t src1;
  reg_idx_t src2;
  logic     has_src1;
  logic     two_src;
  logic     wb_valid;
  reg_idx_t wb_dest;
  logic     flush;
  logic     hazard;

  modport master (
    output issue_valid, issue_wb_en, issue_dest, src1, src2, has_src1, two_src,
    output wb_valid, wb_dest, flush,
    input  hazard
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, src1, src2, has_src1, two_src,
    input  wb_valid, wb_dest, flush,
    output hazard
  );

endinterface

// File: rtl/register_scoreboard_counter.sv
// sb_counter: one saturating in-flight write counter; never wraps in either direction.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic max,
  output logic one,
  output logic underflow
);

  localparam logic [CNT_W-1:0] MaxVal = '1;
  localparam logic [CNT_W-1:0] OneVal = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero      = (cnt_q == '0);
  assign max       = (cnt_q == MaxVal);
  assign one       = (cnt_q == OneVal);
  // A simultaneous inc cancels the dec, so only a lone dec on zero is an underflow.
  assign underflow = dec && !inc && !clr && zero;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !max) begin
      cnt_d = cnt_q + OneVal;
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - OneVal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and raises ID hazards.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback clear a last-pending source.
module register_scoreboard #(
  parameter int CNT_W = register_scoreboard_pkg::CNT_W,
  parameter int NREGS = register_scoreboard_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  register_scoreboard_if.slave  sb,
  output logic [NREGS-1:0]      pending,
  output logic [15:0]           stall_cnt,
  output logic                  err_underflow
);
  import register_scoreboard_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [15:0] zeroVec, maxVec, oneVec, uflVec;
  logic        src1Haz, src2Haz, destHaz, hazard;
  logic        issueAccept;
  logic [15:0] stallCnt_q, stallCnt_d;
  logic        errUfl_q, errUfl_d;

  // Untracked slots (including PC) look permanently empty, so they can never stall.
  for (genvar i = 0; i < 16; i++) begin : gReg
    if (i < NREGS && i != PC_IDX) begin : gTracked
      sb_counter #(.CNT_W(CNT_W)) uCnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (issueAccept && (sb.issue_dest == reg_idx_t'(i))),
        .dec       (sb.wb_valid && (sb.wb_dest == reg_idx_t'(i))),
        .clr       (sb.flush),
        .zero      (zeroVec[i]),
        .max       (maxVec[i]),
        .one       (oneVec[i]),
        .underflow (uflVec[i])
      );
    end else begin : gUntracked
      assign zeroVec[i] = 1'b1;
      assign maxVec[i]  = 1'b0;
      assign oneVec[i]  = 1'b0;
      assign uflVec[i]  = 1'b0;
    end
  end

  // The bypass exemption mirrors the negedge register-file write of the final pending value.
  always_comb begin
    src1Haz = sb.has_src1 && !zeroVec[sb.src1] &&
              !(BypassEn && oneVec[sb.src1] && sb.wb_valid && (sb.wb_dest == sb.src1));
    src2Haz = sb.two_src && !zeroVec[sb.src2] &&
              !(BypassEn && oneVec[sb.src2] && sb.wb_valid && (sb.wb_dest == sb.src2));
    destHaz = sb.issue_wb_en && maxVec[sb.issue_dest];
    hazard  = sb.issue_valid && (src1Haz || src2Haz || destHaz);
    issueAccept = sb.issue_valid && !hazard && !sb.flush && sb.issue_wb_en;
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (hazard && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
    errUfl_d = errUfl_q | (|uflVec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt_q <= '0;
      errUfl_q   <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      errUfl_q   <= errUfl_d;
    end
  end

  assign sb.hazard     = hazard;
  assign pending       = ~zeroVec[NREGS-1:0];
  assign stall_cnt     = stallCnt_q;
  assign err_underflow = errUfl_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed, table-driven bench for register_scoreboard (default or SCOREBOARD_WB_BYPASS_EN build).
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BypassExp = 1'b1;
`else
  localparam bit BypassExp = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic        wbEn;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic        hs1;
    logic [3:0]  s2;
    logic        ts;
    logic        wbv;
    logic [3:0]  wbd;
    logic        fl;
    logic        expHaz;
    logic [14:0] expPend;
    logic        expErr;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREGS-1:0] pending;
  logic [15:0]      stall_cnt;
  logic             err_underflow;

  int compared   = 0;
  int mismatched = 0;
  int expStall   = 0;
  vec_t vecs[$];
  vec_t v;

  register_scoreboard_if sbIf ();

  register_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .sb            (sbIf),
    .pending       (pending),
    .stall_cnt     (stall_cnt),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic wbEn, input int dest,
                              input int s1, input logic hs1, input int s2, input logic ts,
                              input logic wbv, input int wbd, input logic fl,
                              input logic expHaz, input int expPend, input logic expErr);
    vec_t r;
    r.iv = iv; r.wbEn = wbEn; r.dest = 4'(dest); r.s1 = 4'(s1); r.hs1 = hs1;
    r.s2 = 4'(s2); r.ts = ts; r.wbv = wbv; r.wbd = 4'(wbd); r.fl = fl;
    r.expHaz = expHaz; r.expPend = 15'(expPend); r.expErr = expErr;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    sbIf.issue_valid = s.iv;
    sbIf.issue_wb_en = s.wbEn;
    sbIf.issue_dest  = s.dest;
    sbIf.src1        = s.s1;
    sbIf.has_src1    = s.hs1;
    sbIf.src2        = s.s2;
    sbIf.two_src     = s.ts;
    sbIf.wb_valid    = s.wbv;
    sbIf.wb_dest     = s.wbd;
    sbIf.flush       = s.fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // mk(iv, wbEn, dest, s1, hs1, s2, ts, wbv, wbd, flush, expHaz, expPend, expErr)
    vecs.push_back(mk(0,0, 0, 0,0, 0,0, 0,0, 0, 0, 'h0000, 0));
    vecs.push_back(mk(1,1, 3, 0,0, 0,0, 0,0, 0, 0, 'h0008, 0));
    vecs.push_back(mk(1,1, 6, 3,1, 0,0, 0,0, 0, 1, 'h0008, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 0,0, 0, 0, 'h0028, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 0,0, 0, 0, 'h0028, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 0,0, 0, 0, 'h0028, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 0,0, 0, 1, 'h0028, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 1,5, 0, 1, 'h0028, 0));
    vecs.push_back(mk(1,1, 5, 0,0, 0,0, 0,0, 0, 0, 'h0028, 0));
    vecs.push_back(mk(1,0, 0, 0,0, 5,1, 0,0, 0, 1, 'h0028, 0));
    vecs.push_back(mk(0,0, 0, 0,0, 0,0, 1,3, 0, 0, 'h0020, 0));
    vecs.push_back(mk(1,1,15,15,1,15,1, 0,0, 0, 0, 'h0020, 0));
    vecs.push_back(mk(1,0, 0, 5,0, 5,0, 0,0, 0, 0, 'h0020, 0));
    vecs.push_back(mk(0,1, 5, 5,1, 5,1, 0,0, 0, 0, 'h0020, 0));
    vecs.push_back(mk(1,1, 2, 0,0, 0,0, 0,0, 0, 0, 'h0024, 0));
    vecs.push_back(mk(1,1, 2, 0,0, 0,0, 1,2, 0, 0, 'h0024, 0));
    vecs.push_back(mk(0,0, 0, 0,0, 0,0, 1,7, 0, 0, 'h0024, 1));
    vecs.push_back(mk(1,1, 1, 0,0, 0,0, 0,0, 0, 0, 'h0026, 1));
    vecs.push_back(mk(1,0, 0, 0,0, 1,1, 1,1, 0, !BypassExp, 'h0024, 1));
    vecs.push_back(mk(1,1, 4, 0,0, 0,0, 1,2, 1, 0, 'h0000, 1));
    vecs.push_back(mk(0,0, 0, 0,0, 0,0, 0,0, 0, 0, 'h0000, 1));

    rst = 1'b0;
    applyStimulus(vecs[0]);
    #12;
    checkOutput("reset pending", 32'(pending), 32'h0);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("reset err_underflow", 32'(err_underflow), 32'h0);
    checkOutput("reset hazard", 32'(sbIf.hazard), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d hazard", i), 32'(sbIf.hazard), 32'(vecs[i].expHaz));
      if (vecs[i].expHaz) expStall++;
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].expPend));
      checkOutput($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(expStall));
      checkOutput($sformatf("v%0d err_underflow", i), 32'(err_underflow), 32'(vecs[i].expErr));
    end

    // Load counters, then drop reset between edges and expect everything cleared at once.
    @(negedge clk);
    v = mk(1,1, 0, 0,0, 0,0, 0,0, 0, 0, 0, 0);
    applyStimulus(v);
    @(negedge clk);
    v = mk(1,1, 9, 0,0, 0,0, 0,0, 0, 0, 0, 0);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput("loaded pending", 32'(pending), 32'h0201);
    @(negedge clk);
    v = mk(1,0, 0, 0,1, 0,0, 0,0, 0, 0, 0, 0);
    applyStimulus(v);
    #1;
    checkOutput("loaded hazard", 32'(sbIf.hazard), 32'h1);
    #1 rst = 1'b0;
    #1;
    checkOutput("async pending", 32'(pending), 32'h0);
    checkOutput("async stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("async err_underflow", 32'(err_underflow), 32'h0);
    checkOutput("async hazard", 32'(sbIf.hazard), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("held pending", 32'(pending), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    v = mk(1,1, 9, 0,0, 0,0, 0,0, 0, 0, 0, 0);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput("first edge pending", 32'(pending), 32'h0200);
    checkOutput("first edge stall_cnt", 32'(stall_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
